bit_serial_alu_seq: RTL and testbench

- Sequencer that time-multiplexes one external 1-bit ALU slice to execute a full WIDTH-bit ALU operation, LSB first, one bit per clock.
- Holds operands and carry, drives the slice each cycle, assembles the result and flags, and handshakes with the issuing control unit via start/busy/done.
- Sits between the processor control path and the ALU slice; an area-reduced alternative to a WIDTH-wide ripple ALU.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/bit_serial_alu_seq.sv | 138 +++++++++++++
 tb/tb_bit_serial_alu_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes, sequencer state encoding and opcode helpers.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SLT_FIX = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Operations that subtract need carry-in 1 for the two's-complement of B.
  function automatic logic is_sub(input logic [3:0] ctl);
    return (ctl == ALU_SUB) || (ctl == ALU_SLT);
  endfunction

  function automatic logic is_addsub(input logic [3:0] ctl);
    return (ctl == ALU_ADD) || (ctl == ALU_SUB);
  endfunction

  function automatic logic is_known(input logic [3:0] ctl);
    return (ctl == ALU_AND) || (ctl == ALU_OR) || (ctl == ALU_ADD) ||
           (ctl == ALU_SUB) || (ctl == ALU_SLT) || (ctl == ALU_XOR);
  endfunction

endpackage

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: drives an external 1-bit slice LSB first and
// assembles a WIDTH-bit result with zero/overflow flags.
module bit_serial_alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_slt,
  output logic [3:0]       slice_ctl,
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [3:0]       ctl;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             sign;
  logic             ovf_raw;

  logic             bit_in;
  logic [WIDTH-1:0] result_nxt;
  logic             ovf_nxt;

  // Unknown opcodes still run the full sequence but assemble zeros.
  always_comb begin
    bit_in     = is_known(ctl) ? slice_out : 1'b0;
    result_nxt = {bit_in, result[WIDTH-1:1]};
    ovf_nxt    = carry ^ slice_cout;
  end

  // Slice drive is a pure decode of registered state, so it is 0 in reset/IDLE.
  always_comb begin
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_slt = 1'b0;
    slice_ctl = 4'b0000;
    case (state)
      ST_RUN: begin
        slice_a   = a_sh[0];
        slice_b   = b_sh[0];
        slice_cin = carry;
        slice_ctl = (ctl == ALU_SLT) ? ALU_SUB : ctl;
      end
      ST_SLT_FIX: begin
        slice_ctl = ALU_SLT;
        slice_slt = sign ^ ovf_raw;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      ctl     <= 4'b0000;
      cnt     <= '0;
      carry   <= 1'b0;
      sign    <= 1'b0;
      ovf_raw <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            ctl   <= alu_ctl;
            cnt   <= '0;
            carry <= is_sub(alu_ctl);
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          result <= result_nxt;
          carry  <= slice_cout;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            sign    <= slice_out;
            ovf_raw <= ovf_nxt;
            if (ctl == ALU_SLT) begin
              state <= ST_SLT_FIX;
            end else begin
              zero  <= (result_nxt == '0);
              ovf   <= is_addsub(ctl) ? ovf_nxt : 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_SLT_FIX: begin
          result <= {{(WIDTH-1){1'b0}}, slice_out};
          zero   <= ~slice_out;
          ovf    <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Scoreboard bench for bit_serial_alu_seq with a behavioural 1-bit ALU slice.
module tb_bit_serial_alu_seq;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic             slice_slt;
  logic [3:0]       slice_ctl;
  logic             slice_out;
  logic             slice_cout;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ovf;
    int               lat;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   done_cnt   = 0;
  int   cyc        = 0;
  int   acc_cyc    = 0;

  bit_serial_alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .alu_ctl(alu_ctl),
    .busy(busy), .done(done), .result(result), .zero(zero), .ovf(ovf),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_slt(slice_slt), .slice_ctl(slice_ctl),
    .slice_out(slice_out), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 1-bit ALU slice.
  always_comb begin
    logic bx;
    bx         = slice_b;
    slice_out  = 1'b0;
    slice_cout = 1'b0;
    case (slice_ctl)
      4'b0000: slice_out = slice_a & slice_b;
      4'b0001: slice_out = slice_a | slice_b;
      4'b1100: slice_out = slice_a ^ slice_b;
      4'b0010, 4'b0110: begin
        if (slice_ctl == 4'b0110) bx = ~slice_b;
        slice_out  = slice_a ^ bx ^ slice_cin;
        slice_cout = (slice_a & bx) | (slice_a & slice_cin) | (bx & slice_cin);
      end
      4'b0111: slice_out = slice_slt;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: tracks accepts and checks every done pulse against the queue.
  always @(negedge clk) begin
    if (rst_n && start && !busy) acc_cyc = cyc;
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got result 0x%0h, expected no done", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_result"}, 64'(result), 64'(e.res));
        chk({e.name, "_zero"}, 64'(zero), 64'(e.zero));
        chk({e.name, "_ovf"}, 64'(ovf), 64'(e.ovf));
        chk({e.name, "_latency"}, 64'(cyc - acc_cyc), 64'(e.lat));
      end
    end
  end

  task automatic wait_dones(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (done_cnt < target) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got %0d dones expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] c, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] r,
                        input logic z, input logic o);
    int target;
    exp_t e;
    e.res = r; e.zero = z; e.ovf = o; e.name = name;
    e.lat = (c == ALU_SLT) ? WIDTH + 2 : WIDTH + 1;
    target = done_cnt + 1;
    @(negedge clk);
    exp_q.push_back(e);
    start = 1'b1; a = va; b = vb; alu_ctl = c;
    @(posedge clk);
    #1 start = 1'b0;
    wait_dones(target, name);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_flags"}, 64'({zero, ovf}), 64'd0);
    chk({tag, "_slice"}, 64'({slice_a, slice_b, slice_cin, slice_slt, slice_ctl}), 64'd0);
  endtask

  initial begin
    exp_t e;
    int target;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; alu_ctl = 4'b0000;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf",  ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub_neg",  ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_zero", ALU_SUB, 32'd9, 32'd9, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_ovf",  ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("slt_m1",   ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    run_op("slt_ovf",  ALU_SLT, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0);
    run_op("slt_ge",   ALU_SLT, 32'd3, 32'd2, 32'd0, 1'b1, 1'b0);
    run_op("and",      ALU_AND, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h00F0_A5A5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("and_hold_idle", 64'(result), 64'h00F0_A5A5);
    run_op("or",       ALU_OR,  32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0);
    run_op("xor",      ALU_XOR, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'hFF00_5A5A, 1'b0, 1'b0);
    run_op("bad_code", 4'b1010, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 32'h0000_0000, 1'b1, 1'b0);

    // start held high: operand change mid-op must not disturb the first result.
    target = done_cnt + 2;
    @(negedge clk);
    e.zero = 1'b0; e.ovf = 1'b0; e.lat = WIDTH + 1;
    e.res = 32'd3;   e.name = "hold_first";  exp_q.push_back(e);
    e.res = 32'd200; e.name = "hold_second"; exp_q.push_back(e);
    start = 1'b1; a = 32'd1; b = 32'd2; alu_ctl = ALU_ADD;
    @(posedge clk);
    #1 a = 32'd100; b = 32'd100;
    wait_dones(target, "hold");
    start = 1'b0;

    // Reset in the middle of RUN abandons the op silently.
    run_op("pre_rst", ALU_ADD, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 32'd10; b = 32'd20; alu_ctl = ALU_ADD;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_run_busy", 64'(busy), 64'd1);
    chk("mid_run_ctl", 64'(slice_ctl), 64'(ALU_ADD));
    rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
